// File: rtl/can_frame_scheduler.sv
// Periodic multi-channel CAN transmit scheduler: per-round channel walk, payload snapshot,
// bounded retry and status. Optional macro RESULT_TIMEOUT_EN bounds the result wait.
module can_frame_scheduler #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned PERIOD_CYCLES  = 50_000_000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    ch_enable,
  input  logic [NUM_CH*11-1:0] ch_id,
  input  logic [NUM_CH*64-1:0] ch_data,
  input  logic [NUM_CH*8-1:0]  ch_keep,
  output logic [63:0]          stm_send_data_out_tdata,
  output logic [10:0]          stm_send_data_out_tid,
  output logic [7:0]           stm_send_data_out_tkeep,
  output logic                 stm_send_data_out_tvalid,
  input  logic                 stm_send_data_out_tready,
  input  logic [2:0]           stm_result_in_tdata,
  input  logic                 stm_result_in_tvalid,
  output logic                 stm_result_in_tready,
  output logic                 frame_done,
  output logic [3:0]           frame_ch,
  output logic                 frame_fail,
  output logic [2:0]           last_result,
  output logic                 round_busy
);

  localparam int unsigned IDX_W = $clog2(NUM_CH + 1);
  localparam int unsigned CNT_W = $clog2(PERIOD_CYCLES);
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {S_WAIT, S_SCAN, S_SEND, S_RESULT} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_round_start;
  logic [NUM_CH-1:0]   r_en_q;
  logic [IDX_W-1:0]    r_ch_idx;
  logic [RTY_W-1:0]    r_retry;
  logic                r_tvalid;
  logic                r_tready;
  logic [63:0]         r_tdata;
  logic [10:0]         r_tid;
  logic [7:0]          r_tkeep;
  logic                r_frame_done;
  logic [3:0]          r_frame_ch;
  logic                r_frame_fail;
  logic [2:0]          r_last_result;
  logic                r_round_busy;

  logic                w_wrap;
  logic                w_scan_end;
  logic                w_sel_en;
  logic [10:0]         w_sel_id;
  logic [63:0]         w_sel_data;
  logic [7:0]          w_sel_keep;
  logic                w_res_hs;
  logic                w_res_evt;
  logic [2:0]          w_res_val;

  assign w_wrap = (r_cnt == CNT_W'(PERIOD_CYCLES - 1));

  // Free-running period counter; round_start is registered so it is independent of bus delays.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt         <= '0;
      r_round_start <= 1'b0;
    end else begin
      r_round_start <= w_wrap;
      r_cnt         <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_sel_en   = 1'b0;
    w_sel_id   = '0;
    w_sel_data = '0;
    w_sel_keep = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_ch_idx == IDX_W'(i)) begin
        w_sel_en   = r_en_q[i];
        w_sel_id   = ch_id[i*11 +: 11];
        w_sel_data = ch_data[i*64 +: 64];
        w_sel_keep = ch_keep[i*8 +: 8];
      end
    end
  end

  assign w_scan_end = (r_ch_idx == IDX_W'(NUM_CH));
  assign w_res_hs   = stm_result_in_tvalid && r_tready;

`ifdef RESULT_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] r_to_cnt;
  logic            w_timeout;

  // Held at zero outside RESULT so every attempt gets a fresh wait window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    r_to_cnt <= '0;
    else if (r_state != S_RESULT) r_to_cnt <= '0;
    else                          r_to_cnt <= r_to_cnt + 1'b1;
  end

  assign w_timeout = (r_state == S_RESULT) && !w_res_hs &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_res_evt = w_res_hs || w_timeout;
  assign w_res_val = w_res_hs ? stm_result_in_tdata : 3'b010;
`else
  assign w_res_evt = w_res_hs;
  assign w_res_val = stm_result_in_tdata;

  // TIMEOUT_CYCLES has no effect here: the result wait is unbounded.
  if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_WAIT;
      r_en_q        <= '0;
      r_ch_idx      <= '0;
      r_retry       <= '0;
      r_tvalid      <= 1'b0;
      r_tready      <= 1'b0;
      r_tdata       <= '0;
      r_tid         <= '0;
      r_tkeep       <= '0;
      r_frame_done  <= 1'b0;
      r_frame_ch    <= '0;
      r_frame_fail  <= 1'b0;
      r_last_result <= '0;
      r_round_busy  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_WAIT: begin
          if (r_round_start) begin
            r_en_q       <= ch_enable;
            r_ch_idx     <= '0;
            r_round_busy <= 1'b1;
            r_state      <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_scan_end) begin
            r_round_busy <= 1'b0;
            r_state      <= S_WAIT;
          end else if (w_sel_en) begin
            // The output registers double as the frame snapshot for all retries.
            r_tid    <= w_sel_id;
            r_tdata  <= w_sel_data;
            r_tkeep  <= w_sel_keep;
            r_retry  <= '0;
            r_tvalid <= 1'b1;
            r_state  <= S_SEND;
          end else begin
            r_ch_idx <= r_ch_idx + 1'b1;
          end
        end
        S_SEND: begin
          if (stm_send_data_out_tready) begin
            r_tvalid <= 1'b0;
            r_tready <= 1'b1;
            r_state  <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (w_res_evt) begin
            r_tready      <= 1'b0;
            r_last_result <= w_res_val;
            if ((w_res_val != 3'b000) && (r_retry < RTY_W'(MAX_RETRY))) begin
              r_retry  <= r_retry + 1'b1;
              r_tvalid <= 1'b1;
              r_state  <= S_SEND;
            end else begin
              r_frame_done <= 1'b1;
              r_frame_fail <= (w_res_val != 3'b000);
              r_frame_ch   <= 4'(r_ch_idx);
              r_ch_idx     <= r_ch_idx + 1'b1;
              r_state      <= S_SCAN;
            end
          end
        end
        default: r_state <= S_WAIT;
      endcase
    end
  end

  assign stm_send_data_out_tdata  = r_tdata;
  assign stm_send_data_out_tid    = r_tid;
  assign stm_send_data_out_tkeep  = r_tkeep;
  assign stm_send_data_out_tvalid = r_tvalid;
  assign stm_result_in_tready     = r_tready;
  assign frame_done               = r_frame_done;
  assign frame_ch                 = r_frame_ch;
  assign frame_fail               = r_frame_fail;
  assign last_result              = r_last_result;
  assign round_busy               = r_round_busy;

endmodule

// File: doc/can_frame_scheduler.md
Name: can_frame_scheduler

Overview:
- Multi-channel periodic CAN transmit scheduler.
- Once per period, walks NUM_CH channels in ascending index order and issues one frame per enabled channel on the AXI4-Stream send port. It then waits on the AXI4-Stream result port before moving on.
- Adds per-channel ID/DLC, payload snapshotting, bounded retry on failure, and status outputs.
- Sits between vehicle-data producers (engine rev, speed, battery) and the CAN controller.

Parameters:
- NUM_CH, 4, number of transmit channels (1..16).
- PERIOD_CYCLES, 50_000_000, clk cycles from one round start to the next round start (>= 16).
- MAX_RETRY, 3, extra attempts after a failed send (0 = no retry).
- TIMEOUT_CYCLES, 1_000_000, result wait limit; used only with RESULT_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ch_enable  in  NUM_CH  bit i enables channel i; sampled at round start.
- ch_id  in  NUM_CH*11  channel i ID at bits [11i+10:11i].
- ch_data  in  NUM_CH*64  channel i payload.
- ch_keep  in  NUM_CH*8  channel i byte-valid mask (tkeep).
- stm_send_data_out_tdata  out  64  frame payload.
- stm_send_data_out_tid  out  11  frame ID.
- stm_send_data_out_tkeep  out  8  byte mask.
- stm_send_data_out_tvalid  out  1
- stm_send_data_out_tready  in  1
- stm_result_in_tdata  in  3  {arb_lost, ack_err, bit_err}.
- stm_result_in_tvalid  in  1
- stm_result_in_tready  out  1
- frame_done  out  1  1-cycle pulse: frame finished (success or final failure).
- frame_ch  out  4  channel index of the last frame_done.
- frame_fail  out  1  valid with frame_done: retries exhausted.
- last_result  out  3  result tdata of the last accepted result beat.
- round_busy  out  1  high from round start until the round enters WAIT.

Behaviour:
- Reset (async assert, sync release):
  - state=WAIT with the period counter loaded so the first round starts PERIOD_CYCLES cycles after release.
  - All outputs 0: tvalid, tready, tdata, tid, tkeep, frame_done, frame_ch, frame_fail, last_result, round_busy.
- Period counter:
  - Free-running 0..PERIOD_CYCLES-1, wraps to 0.
  - Wrap sets round_start. Start times do not depend on bus delays.
- States:
  - WAIT: on round_start, latch ch_enable into en_q, set ch_idx=0, go SCAN, round_busy=1.
  - SCAN: if ch_idx==NUM_CH, go WAIT and clear round_busy. Else if en_q[ch_idx], snapshot ch_id/ch_data/ch_keep of ch_idx into holding regs, clear retry_cnt, go SEND. Else ch_idx++. Costs one cycle per channel.
  - SEND: tvalid=1; outputs driven from holding regs only. tdata/tid/tkeep stay stable while tvalid && !tready. On tvalid&&tready go RESULT the next cycle.
  - RESULT: tready=1. On tvalid&&tready, capture last_result.
    - tdata==0 is success: pulse frame_done, frame_fail=0, ch_idx++, go SCAN.
    - Nonzero with retry_cnt<MAX_RETRY: retry_cnt++, go SEND with the same snapshot.
    - Otherwise: frame_done=1, frame_fail=1, ch_idx++, go SCAN.
- tvalid and tready are never high together. Neither port is asserted outside its own state.
- Inputs changing mid-round have no effect on an in-flight frame; they take effect at that channel's next snapshot.
- round_start arriving while round_busy=1 is dropped: no queueing, no pulse, and the current round continues.
- Latency:
  - Round start to first tvalid: 2 + (index of first enabled channel) cycles.
  - Channel-to-channel gap after frame_done: 1 + skipped-channel count cycles.
- frame_ch holds its value until the next frame_done.
- Reset asserted mid-operation aborts immediately: tvalid/tready drop combinationally with state, and no frame_done is produced.

Optional Feature:
- Macro RESULT_TIMEOUT_EN.
- Defined:
  - A counter runs in RESULT state.
  - If TIMEOUT_CYCLES elapse with no result beat, the attempt is treated as failed with last_result=3'b010 (ack_err) and the normal retry/fail rules apply.
  - The counter clears on entering RESULT.
- Undefined: RESULT waits indefinitely; no counter logic is synthesised.

Test Plan:
- NUM_CH=4, PERIOD_CYCLES=200, ch_enable=4'b1011, tready and result always ready with 0 -> three frames per round with tid = ch_id[0], ch_id[1], ch_id[3] in that order; frame_ch=0,1,3; frame_fail=0; rounds start exactly 200 cycles apart.
- Hold tready=0 for 10 cycles while changing ch_data[0] -> tdata unchanged (old snapshot), tvalid held high; transfer completes when tready rises.
- Result 3'b100 twice, then 0, with MAX_RETRY=3 -> same frame resent twice more; one frame_done with frame_fail=0 and last_result=0.
- Result 3'b001 on all attempts, MAX_RETRY=2 -> exactly 3 send beats; frame_done with frame_fail=1 and last_result=3'b001; scheduler proceeds to next channel.
- Stall result tvalid beyond PERIOD_CYCLES -> next round_start ignored; round_busy stays 1; no duplicate frames.
- Assert reset during SEND -> tvalid=0 in the same cycle; after release, first tvalid appears at PERIOD_CYCLES+2 cycles. With RESULT_TIMEOUT_EN, TIMEOUT_CYCLES=50 and no result -> ack_err retry after 50 cycles.
